// File: rtl/uartlite_responder.sv
// AXI4-Lite responder modelling the UART Lite register map with RX/TX byte FIFOs.
// Optional: define UARTLITE_CTRL_REG_EN to enable the control register at 0xC.
module uartlite_responder #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    input  logic [3:0]  AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID
);
    localparam logic [FIFO_AW:0] FULL_CNT = FIFO_DEPTH[FIFO_AW:0];

    typedef enum logic {R_IDLE, R_RESP} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;

    rstate_t rstate, rstate_nxt;
    wstate_t wstate, wstate_nxt;

    logic rst_done, ar_hs, aw_hs, w_hs, exec;
    logic aw_got, w_got, wstb;
    logic [1:0] aw_idx;
    logic [7:0] wbyte;
    logic tx_rst, rx_rst, intr_bit, overrun;

    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [FIFO_AW:0] tx_cnt, rx_cnt;
    logic tx_empty, tx_full, tx_push, tx_pop;
    logic rx_empty, rx_full, rx_push, rx_pop;
    logic [31:0] status;
    logic unused_bits;

    assign unused_bits = ^{ARADDR[1:0], AWADDR[1:0], WDATA[31:8], WSTRB[3:1]};
    assign RRESP = 2'b00;
    assign BRESP = 2'b00;

    // Holds the ready outputs low for the first cycle after reset release.
    always_ff @(posedge CLK) begin
        if (!RST_N) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) rstate <= R_IDLE;
        else        rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt = rstate;
        ARREADY    = 1'b0;
        RVALID     = 1'b0;
        case (rstate)
            R_IDLE: begin
                ARREADY = rst_done;
                if (ARVALID && rst_done) rstate_nxt = R_RESP;
            end
            R_RESP: begin
                RVALID = 1'b1;
                if (RREADY) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    assign ar_hs  = ARVALID && ARREADY;
    assign status = {26'b0, overrun, intr_bit, tx_full, tx_empty, rx_full, !rx_empty};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            RDATA <= 32'h0;
        end else if (ar_hs) begin
            case (ARADDR[3:2])
                2'd0:    RDATA <= rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp]};
                2'd2:    RDATA <= status;
                default: RDATA <= 32'h0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) wstate <= W_IDLE;
        else        wstate <= wstate_nxt;
    end

    always_comb begin
        wstate_nxt = wstate;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        case (wstate)
            W_IDLE: begin
                AWREADY = rst_done && !aw_got;
                WREADY  = rst_done && !w_got;
                if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY)))
                    wstate_nxt = W_EXEC;
            end
            W_EXEC: wstate_nxt = W_RESP;
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign exec  = (wstate == W_EXEC);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            aw_idx <= 2'd0;
            wbyte  <= 8'h0;
            wstb   <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_idx <= AWADDR[3:2];
            end
            if (w_hs) begin
                w_got <= 1'b1;
                wbyte <= WDATA[7:0];
                wstb  <= WSTRB[0];
            end
            if (exec) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

`ifdef UARTLITE_CTRL_REG_EN
    logic ctrl_wr, intr_en;
    assign ctrl_wr  = exec && (aw_idx == 2'd3) && wstb;
    assign tx_rst   = ctrl_wr && wbyte[0];
    assign rx_rst   = ctrl_wr && wbyte[1];
    assign intr_bit = intr_en;
    always_ff @(posedge CLK) begin
        if (!RST_N)       intr_en <= 1'b0;
        else if (ctrl_wr) intr_en <= wbyte[4];
    end
`else
    assign tx_rst   = 1'b0;
    assign rx_rst   = 1'b0;
    assign intr_bit = 1'b0;
`endif

    // TX FIFO: a pop frees the head slot, so a push on full is taken alongside it.
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_pop   = TX_READY && !tx_empty;
    assign tx_push  = exec && (aw_idx == 2'd1) && wstb && (!tx_full || tx_pop);
    assign TX_VALID = !tx_empty;
    assign TX_DATA  = tx_empty ? 8'h00 : tx_mem[tx_rp];

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wp] <= wbyte;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N || tx_rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_pop   = ar_hs && (ARADDR[3:2] == 2'd0) && !rx_empty;
    assign rx_push  = RX_VALID && (!rx_full || rx_pop);

    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[rx_wp] <= RX_DATA;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N || rx_rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // A dropped byte outranks a same-cycle status read clearing the flag.
    always_ff @(posedge CLK) begin
        if (!RST_N || rx_rst)                       overrun <= 1'b0;
        else if (RX_VALID && rx_full && !rx_pop)    overrun <= 1'b1;
        else if (ar_hs && (ARADDR[3:2] == 2'd2))    overrun <= 1'b0;
    end
endmodule

// File: tb/tb_uartlite_responder.sv
// Directed bench for uartlite_responder: reset, status, RX/TX FIFO paths, overrun, full boundaries.
module tb_uartlite_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  araddr, awaddr;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    uartlite_responder dut (
        .CLK(clk), .RST_N(rst_n),
        .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
        .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
        .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
        .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
        .RX_DATA(rx_data), .RX_VALID(rx_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 50) begin tick(); n++; end
        chk("ar_ready", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        chk("rvalid_lat", {31'b0, rvalid}, 32'd1);
        chk("rresp", {30'b0, rresp}, 32'd0);
        d = rdata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    // lead: cycles W precedes AW; bwait: cycles BREADY is held low; pop: TX_READY during the exec cycle
    task automatic axi_write(input logic [3:0] a, input logic [7:0] d, input int lead,
                             input int bwait, input logic pop);
        wdata = {24'hA5A5A5, d}; wstrb = 4'h1; wvalid = 1'b1;
        if (lead > 0) begin
            tick();
            wvalid = 1'b0;
            chk("w_captured", {30'b0, awready, wready}, 32'h2);
            for (int i = 1; i < lead; i++) tick();
        end
        awaddr = a; awvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tx_ready = pop;
        chk("b_exec", {29'b0, awready, wready, bvalid}, 32'd0);
        tick();
        tx_ready = 1'b0;
        chk("b_resp", {29'b0, bresp, bvalid}, 32'd1);
        for (int i = 0; i < bwait; i++) tick();
        if (bwait > 0) chk("b_hold", {31'b0, bvalid}, 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b_done", {31'b0, bvalid}, 32'd0);
    endtask

    task automatic tx_pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, exp});
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; araddr = '0; arvalid = 0; rready = 0; awaddr = '0; awvalid = 0;
        wdata = '0; wstrb = '0; wvalid = 0; bready = 0; tx_ready = 0; rx_data = '0; rx_valid = 0;
        repeat (3) tick();
        chk("rst_ready", {29'b0, arready, awready, wready}, 32'd0);
        chk("rst_valid", {29'b0, rvalid, bvalid, tx_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_txdata", {24'b0, tx_data}, 32'd0);
        rst_n = 1'b1;
        chk("rdy_pre", {29'b0, arready, awready, wready}, 32'd0);
        tick();
        chk("rdy_post", {29'b0, arready, awready, wready}, 32'd7);

        axi_read(4'h8, rd); chk("stat_reset", rd, 32'h4);

        rx_valid = 1'b1; rx_data = 8'h41; tick();
        rx_data = 8'h42; tick();
        rx_valid = 1'b0;
        axi_read(4'h8, rd); chk("stat_rx2", rd, 32'h5);
        axi_read(4'h4, rd); chk("rd_0x4", rd, 32'h0);
        axi_read(4'h0, rd); chk("rx_41", rd, 32'h41);
        axi_read(4'h0, rd); chk("rx_42", rd, 32'h42);
        axi_read(4'h8, rd); chk("stat_rx0", rd, 32'h4);
        axi_read(4'h0, rd); chk("rx_empty_rd", rd, 32'h0);

        axi_write(4'h4, 8'h5A, 0, 0, 1'b0);
        chk("tx_5a", {23'b0, tx_valid, tx_data}, 32'h15A);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        chk("tx_popped", {31'b0, tx_valid}, 32'd0);

        axi_write(4'h0, 8'h99, 0, 0, 1'b0);
        chk("wr_other", {31'b0, tx_valid}, 32'd0);

        axi_write(4'h4, 8'h77, 3, 4, 1'b0);
        chk("tx_77", {23'b0, tx_valid, tx_data}, 32'h177);

        rx_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin rx_data = 8'(i); tick(); end
        rx_valid = 1'b0;
        axi_read(4'h8, rd); chk("stat_ovr", rd, 32'h23);
        axi_read(4'h8, rd); chk("stat_ovr_clr", rd, 32'h03);
        for (int i = 1; i <= 16; i++) begin
            axi_read(4'h0, rd); chk("rx_seq", rd, 32'(i));
        end
        axi_read(4'h8, rd); chk("stat_drained", rd, 32'h0);

        for (int i = 1; i <= 15; i++) axi_write(4'h4, 8'(8'h80 + i), 0, 0, 1'b0);
        axi_read(4'h8, rd); chk("stat_txfull", rd, 32'h08);
        axi_write(4'h4, 8'hEE, 0, 0, 1'b0);
        axi_read(4'h8, rd); chk("stat_drop", rd, 32'h08);
        chk("tx_head_kept", {24'b0, tx_data}, 32'h77);
        axi_write(4'h4, 8'hAB, 0, 0, 1'b1);
        axi_read(4'h8, rd); chk("stat_full_pp", rd, 32'h08);
        for (int i = 1; i <= 15; i++) tx_pop_chk("tx_seq", 8'(8'h80 + i));
        tx_pop_chk("tx_tail", 8'hAB);
        chk("tx_final_empty", {31'b0, tx_valid}, 32'd0);

        araddr = 4'h8; arvalid = 1'b1; tick();
        arvalid = 1'b0;
        chk("mid_rvalid", {31'b0, rvalid}, 32'd1);
        rst_n = 1'b0; tick();
        chk("mid_rst", {31'b0, rvalid}, 32'd0);
        chk("mid_rdata", rdata, 32'd0);
        rst_n = 1'b1; tick();
        chk("mid_ready", {31'b0, arready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
